// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTransIdle   = 2'd0,
    HTransBusy   = 2'd1,
    HTransNonseq = 2'd2,
    HTransSeq    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSizeByte  = 3'd0,
    HSizeHalf  = 3'd1,
    HSizeWord  = 3'd2,
    HSizeDword = 3'd3
  } hsize_e;

  localparam logic HRespOkay  = 1'b0;
  localparam logic HRespError = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slave_state_e;

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between a master/decoder and the SRAM slave.
interface ahb_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic [1:0]            htrans;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hwrite;
  logic                  hready_in;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  modport master (
    output hsel, haddr, hburst, hsize, htrans, hwdata, hwrite, hready_in,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hburst, hsize, htrans, hwdata, hwrite, hready_in,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_sram_array.sv
// Word-organised single-port storage: asynchronous read, byte-enabled synchronous write.
module ahb_sram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned IdxW      = $clog2(MEM_DEPTH),
  localparam int unsigned ByteLanes = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ByteLanes-1:0]  be_i,
  input  logic [IdxW-1:0]       idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(ByteLanes); b++) begin
        if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states.
// Define AHB_SRAM_ERR_EN to answer out-of-range or oversized accesses with a two-cycle ERROR.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic               hclk,
  input logic               hresetn,
  ahb_sram_slave_if.slave   bus
);

  localparam int unsigned ByteLanes = DATA_WIDTH / 8;
  localparam int unsigned OffW      = $clog2(ByteLanes);
  localparam int unsigned IdxW      = $clog2(MEM_DEPTH);
  localparam int unsigned AW        = IdxW + OffW;
  localparam logic [1:0]  WaitCnt   = 2'(WAIT_STATES);
  localparam logic [2:0]  MaxSize   = 3'(OffW);

  slave_state_e          state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  dphase_q, dphase_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] hrdata_q, rdata;
  logic                  hready_int, complete, accept, req_err, we;
  logic [ByteLanes-1:0]  be;
  logic [2:0]            eff_size;
  int                    nbytes, off;

  assign accept = bus.hsel & bus.hready_in & bus.htrans[1];

`ifdef AHB_SRAM_ERR_EN
  assign req_err = ((bus.haddr >> AW) != '0) | (bus.hsize > MaxSize);
`else
  assign req_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dphase_d   = dphase_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    hready_int = 1'b1;
    complete   = 1'b0;
    unique case (state_q)
      StIdle: complete = dphase_q;
      StWait: begin
        hready_int = (cnt_q == WaitCnt);
        complete   = hready_int;
        if (!hready_int) cnt_d = cnt_q + 2'd1;
      end
      StErr1: begin
        hready_int = 1'b0;
        state_d    = StErr2;
      end
      StErr2: ;
      default: ;
    endcase
    // Any cycle with hready high closes the current data phase and samples a new address phase.
    if (hready_int) begin
      state_d  = StIdle;
      cnt_d    = '0;
      dphase_d = 1'b0;
      if (accept) begin
        if (req_err) begin
          state_d = StErr1;
        end else begin
          state_d  = (WAIT_STATES > 0) ? StWait : StIdle;
          dphase_d = 1'b1;
          addr_d   = bus.haddr[AW-1:0];
          size_d   = bus.hsize;
          write_d  = bus.hwrite;
        end
      end
    end
  end

  // Little-endian lane select; low address bits are aligned down to the transfer size.
  always_comb begin
    eff_size = (size_q > MaxSize) ? MaxSize : size_q;
    nbytes   = 1 << eff_size;
    off      = int'(addr_q[OffW-1:0]) & ~(nbytes - 1);
    for (int b = 0; b < int'(ByteLanes); b++) begin
      be[b] = (b >= off) && (b < off + nbytes);
    end
  end

  assign we = complete & write_q & hresetn;

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      if (complete && !write_q) hrdata_q <= rdata;
    end
  end

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk_i   (hclk),
    .we_i    (we),
    .be_i    (be),
    .idx_i   (addr_q[AW-1:OffW]),
    .wdata_i (bus.hwdata),
    .rdata_o (rdata)
  );

  assign bus.hrdata = hrdata_q;
  assign bus.hready = hready_int;
`ifdef AHB_SRAM_ERR_EN
  assign bus.hresp  = (state_q == StErr1 || state_q == StErr2) ? HRespError : HRespOkay;
`else
  assign bus.hresp  = HRespOkay;
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.hburst, bus.htrans[0], bus.haddr};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one slave with one wait state, one with zero wait states.
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic hold_off = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 hclk = ~hclk;

  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();

  assign bus1.hready_in = hold_off ? 1'b0 : bus1.hready;
  assign bus0.hready_in = bus0.hready;

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(1)
  ) u_dut1 (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus1)
  );

  ahb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)
  ) u_dut0 (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus0)
  );

  task automatic idle_bus();
    bus1.hsel = 1'b0; bus1.htrans = 2'd0; bus1.haddr = '0; bus1.hsize = 3'd2;
    bus1.hwrite = 1'b0; bus1.hwdata = '0; bus1.hburst = 3'd0;
    bus0.hsel = 1'b0; bus0.htrans = 2'd0; bus0.haddr = '0; bus0.hsize = 3'd2;
    bus0.hwrite = 1'b0; bus0.hwdata = '0; bus0.hburst = 3'd0;
  endtask

  // Non-pipelined transfer on bus1; entered and left at posedge+1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output int low, output logic resp,
                      output logic [31:0] rdata);
    bit done;
    bus1.hsel = 1'b1; bus1.htrans = 2'd2; bus1.haddr = addr; bus1.hsize = size;
    bus1.hwrite = wr;
    @(posedge hclk); #1;
    bus1.hsel = 1'b0; bus1.htrans = 2'd0; bus1.hwdata = wdata;
    low = 0; resp = 1'b0; done = 1'b0;
    for (int i = 0; i < 16 && !done; i++) begin
      @(negedge hclk);
      resp = resp | bus1.hresp;
      if (bus1.hready === 1'b1) done = 1'b1;
      else low++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h got=no_hready exp=hready_within_16", addr);
    end
    @(posedge hclk); #1;
    rdata = bus1.hrdata;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    idle_bus();
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b1) begin failures++;
      $display("FAIL reset_hready got=%b exp=1", bus1.hready); end
    checks++; if (bus1.hresp !== 1'b0) begin failures++;
      $display("FAIL reset_hresp got=%b exp=0", bus1.hresp); end
    checks++; if (bus1.hrdata !== 32'h0) begin failures++;
      $display("FAIL reset_hrdata got=%h exp=00000000", bus1.hrdata); end
    checks++; if (bus0.hrdata !== 32'h0) begin failures++;
      $display("FAIL reset_hrdata_ws0 got=%h exp=00000000", bus0.hrdata); end
    @(posedge hclk); #1;
  endtask

  task automatic test_write_read();
    int low; logic resp; logic [31:0] rd;
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, low, resp, rd);
    checks++; if (low !== 1) begin failures++;
      $display("FAIL wr_wait_cycles got=%0d exp=1", low); end
    checks++; if (resp !== 1'b0) begin failures++;
      $display("FAIL wr_resp got=%b exp=0", resp); end
    xfer(1'b0, 32'h10, 3'd2, 32'h0, low, resp, rd);
    checks++; if (low !== 1) begin failures++;
      $display("FAIL rd_wait_cycles got=%0d exp=1", low); end
    checks++; if (resp !== 1'b0) begin failures++;
      $display("FAIL rd_resp got=%b exp=0", resp); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++;
      $display("FAIL rd_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    int low; logic resp; logic [31:0] rd;
    xfer(1'b1, 32'h10, 3'd2, 32'h11223344, low, resp, rd);
    xfer(1'b1, 32'h13, 3'd0, 32'hAA000000, low, resp, rd);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, low, resp, rd);
    checks++; if (rd !== 32'hAA223344) begin failures++;
      $display("FAIL byte_write got=%h exp=aa223344", rd); end
    // Unaligned halfword at 0x15 lands on lanes 0..1 of word 0x14.
    xfer(1'b1, 32'h14, 3'd2, 32'h00000000, low, resp, rd);
    xfer(1'b1, 32'h15, 3'd1, 32'hFFFF5566, low, resp, rd);
    xfer(1'b0, 32'h14, 3'd2, 32'h0, low, resp, rd);
    checks++; if (rd !== 32'h00005566) begin failures++;
      $display("FAIL half_unaligned got=%h exp=00005566", rd); end
  endtask

  task automatic test_out_of_range();
    int low; logic resp; logic [31:0] rd, exp_rd;
    xfer(1'b1, 32'h0, 3'd2, 32'hCAFEF00D, low, resp, rd);
    xfer(1'b1, 32'h4, 3'd2, 32'h600DF00D, low, resp, rd);
    xfer(1'b0, 32'h4, 3'd2, 32'h0, low, resp, rd);
    checks++; if (rd !== 32'h600DF00D) begin failures++;
      $display("FAIL pre_err_read got=%h exp=600df00d", rd); end
    bus1.hsel = 1'b1; bus1.htrans = 2'd2; bus1.haddr = 32'h1000; bus1.hsize = 3'd2;
    bus1.hwrite = 1'b0;
    @(posedge hclk); #1;
    bus1.hsel = 1'b0; bus1.htrans = 2'd0;
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b0) begin failures++;
      $display("FAIL oor_c1_hready got=%b exp=0", bus1.hready); end
    checks++; if (bus1.hresp !== ErrEn) begin failures++;
      $display("FAIL oor_c1_hresp got=%b exp=%b", bus1.hresp, ErrEn); end
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b1) begin failures++;
      $display("FAIL oor_c2_hready got=%b exp=1", bus1.hready); end
    checks++; if (bus1.hresp !== ErrEn) begin failures++;
      $display("FAIL oor_c2_hresp got=%b exp=%b", bus1.hresp, ErrEn); end
    @(posedge hclk); #1;
    exp_rd = ErrEn ? 32'h600DF00D : 32'hCAFEF00D;
    checks++; if (bus1.hrdata !== exp_rd) begin failures++;
      $display("FAIL oor_hrdata got=%h exp=%h", bus1.hrdata, exp_rd); end
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b1 || bus1.hresp !== 1'b0) begin failures++;
      $display("FAIL oor_after got=%b%b exp=10", bus1.hready, bus1.hresp); end
    @(posedge hclk); #1;
    xfer(1'b1, 32'h1000, 3'd2, 32'h12345678, low, resp, rd);
    checks++; if (resp !== ErrEn || low !== 1) begin failures++;
      $display("FAIL oor_write_resp got=%b/%0d exp=%b/1", resp, low, ErrEn); end
    xfer(1'b0, 32'h0, 3'd2, 32'h0, low, resp, rd);
    exp_rd = ErrEn ? 32'hCAFEF00D : 32'h12345678;
    checks++; if (rd !== exp_rd) begin failures++;
      $display("FAIL oor_write_effect got=%h exp=%h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid_wait();
    int low; logic resp; logic [31:0] rd;
    xfer(1'b1, 32'h20, 3'd2, 32'h01020304, low, resp, rd);
    xfer(1'b0, 32'h10, 3'd2, 32'h0, low, resp, rd);
    bus1.hsel = 1'b1; bus1.htrans = 2'd2; bus1.haddr = 32'h20; bus1.hsize = 3'd2;
    bus1.hwrite = 1'b1;
    @(posedge hclk); #1;
    bus1.hsel = 1'b0; bus1.htrans = 2'd0; bus1.hwdata = 32'hFFFFFFFF;
    hresetn = 1'b0;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b1) begin failures++;
      $display("FAIL rst_mid_hready got=%b exp=1", bus1.hready); end
    checks++; if (bus1.hresp !== 1'b0) begin failures++;
      $display("FAIL rst_mid_hresp got=%b exp=0", bus1.hresp); end
    checks++; if (bus1.hrdata !== 32'h0) begin failures++;
      $display("FAIL rst_mid_hrdata got=%h exp=00000000", bus1.hrdata); end
    @(posedge hclk); #1;
    xfer(1'b0, 32'h20, 3'd2, 32'h0, low, resp, rd);
    checks++; if (rd !== 32'h01020304) begin failures++;
      $display("FAIL rst_mid_word got=%h exp=01020304", rd); end
  endtask

  task automatic test_no_accept();
    int low; logic resp; logic [31:0] rd;
    hold_off = 1'b1;
    bus1.hsel = 1'b1; bus1.htrans = 2'd2; bus1.haddr = 32'h20; bus1.hsize = 3'd2;
    bus1.hwrite = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      checks++; if (bus1.hready !== 1'b1) begin failures++;
        $display("FAIL hold_hready got=%b exp=1", bus1.hready); end
      @(posedge hclk); #1;
    end
    bus1.hsel = 1'b0; bus1.htrans = 2'd0; bus1.hwdata = 32'hFFFFFFFF;
    hold_off = 1'b0;
    @(negedge hclk);
    checks++; if (bus1.hready !== 1'b1) begin failures++;
      $display("FAIL hold_after_hready got=%b exp=1", bus1.hready); end
    @(posedge hclk); #1;
    xfer(1'b0, 32'h20, 3'd2, 32'h0, low, resp, rd);
    checks++; if (rd !== 32'h01020304) begin failures++;
      $display("FAIL hold_word got=%h exp=01020304", rd); end
  endtask

  task automatic test_back_to_back();
    bus0.hsel = 1'b1; bus0.htrans = 2'd2; bus0.haddr = 32'h40; bus0.hsize = 3'd2;
    bus0.hwrite = 1'b1;
    @(posedge hclk); #1;
    bus0.hwdata = 32'h0BADC0DE; bus0.hwrite = 1'b0;
    @(negedge hclk);
    checks++; if (bus0.hready !== 1'b1) begin failures++;
      $display("FAIL b2b_wr_hready got=%b exp=1", bus0.hready); end
    @(posedge hclk); #1;
    bus0.hsel = 1'b0; bus0.htrans = 2'd0;
    @(negedge hclk);
    checks++; if (bus0.hready !== 1'b1) begin failures++;
      $display("FAIL b2b_rd_hready got=%b exp=1", bus0.hready); end
    @(posedge hclk); #1;
    checks++; if (bus0.hrdata !== 32'h0BADC0DE) begin failures++;
      $display("FAIL b2b_raw got=%h exp=0badc0de", bus0.hrdata); end
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_reset_mid_wait();
    test_no_accept();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
